// File: rtl/rf_codec_pkg.sv
// Shared definitions for the RF transmit framer and receive deframer:
// sequencer state encoding and default frame-format constants.
package rf_codec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_GUARD    = 3'd4
  } rf_state_e;

  localparam logic [15:0] DEF_SYNC_WORD     = 16'h2DD4;
  localparam int unsigned DEF_SYNC_BITS     = 16;
  localparam int unsigned DEF_PREAMBLE_BITS = 16;
  localparam int unsigned DEF_GUARD_BITS    = 4;
  localparam int unsigned DEF_BIT_CYCLES    = 2;

endpackage

// File: rtl/rf_bit_timer.sv
// Bit-period phase counter. Runs while the owner is active and restarts
// at phase 0 whenever a run begins. bit_stb is registered; bit_end and
// pre_end are decodes of the phase register.
module rf_bit_timer #(
  parameter int unsigned BIT_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_next_i,
  output logic bit_stb_o,
  output logic pre_end_o,
  output logic bit_end_o
);

  localparam int unsigned PW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] PRE  = PW'(BIT_CYCLES - 2);

  logic [PW-1:0] phase_q, phase_d;
  logic          run_q;
  logic          stb_q;

  // Next phase: advance and wrap while running, restart at 0 otherwise.
  always_comb begin
    phase_d = '0;
    if (run_next_i && run_q && (phase_q != LAST)) phase_d = phase_q + PW'(1);
  end

  // Phase, run flag and strobe registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      run_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      run_q   <= run_next_i;
      stb_q   <= run_next_i && (phase_d == '0);
    end
  end

  assign bit_stb_o = stb_q;
  assign bit_end_o = run_q && (phase_q == LAST);
  assign pre_end_o = run_q && (phase_q == PRE);

endmodule

// File: rtl/rf_tx_framer.sv
// Transmit frame sequencer: preamble, sync word, payload bytes MSB first,
// then trailing guard zeros, one NRZ bit per bit period to the line encoder.
module rf_tx_framer
  import rf_codec_pkg::*;
#(
  parameter int unsigned PREAMBLE_BITS = DEF_PREAMBLE_BITS,
  parameter logic [31:0] SYNC_WORD     = 32'(DEF_SYNC_WORD),
  parameter int unsigned SYNC_BITS     = DEF_SYNC_BITS,
  parameter int unsigned GUARD_BITS    = DEF_GUARD_BITS,
  parameter int unsigned BIT_CYCLES    = DEF_BIT_CYCLES
) (
  input  logic       clk2x,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       enc_din,
  output logic       enc_enable,
  output logic       bit_stb,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] PRE_INIT   = CW'(PREAMBLE_BITS - 1);
  localparam logic [CW-1:0] SYNC_INIT  = CW'(SYNC_BITS - 1);
  localparam logic [CW-1:0] GUARD_INIT = CW'(GUARD_BITS - 1);
  localparam logic [4:0]    SYNC_TOP   = 5'(SYNC_BITS - 1);
  localparam bit            NO_GUARD   = (GUARD_BITS == 0);

  rf_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    shreg_q;
  logic          last_q;
  logic          din_q;
  logic          busy_q;
  logic          ready_q;
  logic          und_q;

  logic       bit_end, pre_end;
  logic       cnt_zero, load_pt, frame_end, busy_d;
  logic [4:0] sync_idx;

  rf_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk_i      (clk2x),
    .rst_i      (rst),
    .run_next_i (busy_d),
    .bit_stb_o  (bit_stb),
    .pre_end_o  (pre_end),
    .bit_end_o  (bit_end)
  );

  // Load-point and end-of-frame decodes; busy_d lets the timer restart its
  // phase on the same edge the sequencer enters or leaves IDLE.
  always_comb begin
    cnt_zero  = (cnt_q == '0);
    load_pt   = cnt_zero && ((state_q == ST_SYNC) ||
                             ((state_q == ST_PAYLOAD) && !last_q));
    sync_idx  = 5'(cnt_q - CW'(1));
    frame_end = 1'b0;
    if (bit_end && cnt_zero) begin
      case (state_q)
        ST_GUARD:            frame_end = 1'b1;
        ST_SYNC, ST_PAYLOAD: frame_end = NO_GUARD && !(load_pt && ready_q);
        default:             frame_end = 1'b0;
      endcase
    end
    busy_d = (state_q == ST_IDLE) ? s_valid : !frame_end;
  end

  // Frame sequencer. The ready/underrun decision is taken one cycle before
  // bit_end so both pulses are registered yet coincide with the load edge.
  always_ff @(posedge clk2x) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= 1'b0;
      und_q   <= 1'b0;
      if (pre_end && load_pt) begin
        if (s_valid) ready_q <= 1'b1;
        else         und_q   <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (s_valid) begin
            state_q <= ST_PREAMBLE;
            cnt_q   <= PRE_INIT;
            din_q   <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          if (bit_end) begin
            if (cnt_zero) begin
              state_q <= ST_SYNC;
              cnt_q   <= SYNC_INIT;
              din_q   <= SYNC_WORD[SYNC_TOP];
            end else begin
              cnt_q <= cnt_q - CW'(1);
              din_q <= ~din_q;
            end
          end
        end
        ST_SYNC, ST_PAYLOAD: begin
          if (bit_end) begin
            if (!cnt_zero) begin
              cnt_q <= cnt_q - CW'(1);
              if (state_q == ST_SYNC) begin
                din_q <= SYNC_WORD[sync_idx];
              end else begin
                shreg_q <= shreg_q << 1;
                din_q   <= shreg_q[6];
              end
            end else if (load_pt && ready_q) begin
              state_q <= ST_PAYLOAD;
              cnt_q   <= CW'(7);
              shreg_q <= s_data;
              last_q  <= s_last;
              din_q   <= s_data[7];
            end else if (NO_GUARD) begin
              state_q <= ST_IDLE;
              din_q   <= 1'b0;
            end else begin
              state_q <= ST_GUARD;
              cnt_q   <= GUARD_INIT;
              din_q   <= 1'b0;
            end
          end
        end
        ST_GUARD: begin
          if (bit_end) begin
            if (cnt_zero) begin
              state_q <= ST_IDLE;
              din_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign enc_din    = din_q;
  assign enc_enable = busy_q;
  assign busy       = busy_q;
  assign s_ready    = ready_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_rf_tx_framer.sv
// Bench for rf_tx_framer: a default instance and a short-frame instance
// (PREAMBLE_BITS=1, GUARD_BITS=0, BIT_CYCLES=5), each checked every cycle
// against a per-cycle expectation queue built from the frame contents.
module tb_rf_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic [7:0] sd0, sd1;
  logic       sv0, sv1, sl0, sl1;
  logic       rdy0, din0, en0, stb0, bz0, un0;
  logic       rdy1, din1, en1, stb1, bz1, un1;

  rf_tx_framer u_dut0 (
    .clk2x(clk), .rst(rst0), .s_data(sd0), .s_valid(sv0), .s_last(sl0),
    .s_ready(rdy0), .enc_din(din0), .enc_enable(en0), .bit_stb(stb0),
    .busy(bz0), .underrun(un0)
  );

  rf_tx_framer #(
    .PREAMBLE_BITS(1), .GUARD_BITS(0), .BIT_CYCLES(5)
  ) u_dut1 (
    .clk2x(clk), .rst(rst1), .s_data(sd1), .s_valid(sv1), .s_last(sl1),
    .s_ready(rdy1), .enc_din(din1), .enc_enable(en1), .bit_stb(stb1),
    .busy(bz1), .underrun(un1)
  );

  typedef struct packed {
    logic din, en, stb, busy, rdy, und;
  } exp_t;

  exp_t       q0[$], q1[$], fr[$];
  exp_t       e0, e1;
  logic [7:0] fb [4];
  int vectors = 0, miscompares = 0, cyc = 0;
  int en_cnt0 = 0, rdy_cnt0 = 0, und_cnt0 = 0, lowrun0 = 0, last_lowrun0 = 0;
  int en_cnt1 = 0, stb_cnt1 = 0;
  int rdy_t0[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected per-cycle outputs for one frame, from the frame layout rules.
  task automatic build_frame(input int d, input int n, input int k);
    int         pre, gd, bc;
    logic [15:0] sw;
    logic [7:0] b;
    logic       bits[$];
    int         ev[$];
    exp_t       e;
    sw  = 16'h2DD4;
    pre = (d == 0) ? 16 : 1;
    gd  = (d == 0) ? 4 : 0;
    bc  = (d == 0) ? 2 : 5;
    fr.delete();
    for (int i = 0; i < pre; i++) begin bits.push_back((i % 2) == 0); ev.push_back(0); end
    for (int i = 0; i < 16; i++) begin bits.push_back(sw[15-i]); ev.push_back(0); end
    ev[ev.size()-1] = (k > 0) ? 1 : 2;
    for (int j = 0; j < k; j++) begin
      b = fb[j];
      for (int i = 0; i < 8; i++) begin bits.push_back(b[7-i]); ev.push_back(0); end
      if (j != n - 1) ev[ev.size()-1] = (j + 1 < k) ? 1 : 2;
    end
    for (int i = 0; i < gd; i++) begin bits.push_back(1'b0); ev.push_back(0); end
    for (int i = 0; i < bits.size(); i++) begin
      for (int c = 0; c < bc; c++) begin
        e.din  = bits[i];
        e.en   = 1'b1;
        e.busy = 1'b1;
        e.stb  = (c == 0);
        e.rdy  = (c == bc - 1) && (ev[i] == 1);
        e.und  = (c == bc - 1) && (ev[i] == 2);
        fr.push_back(e);
      end
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] data, input logic last);
    if (d == 0) begin sv0 = v; sd0 = data; sl0 = last; end
    else        begin sv1 = v; sd1 = data; sl1 = last; end
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  // Returns just after the edge that consumes the presented byte.
  task automatic wait_ready(input int d, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      if (rdy_of(d) === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    miscompares++;
    $display("FAIL handshake timeout dut%0d: got no s_ready expected s_ready within 4000 cycles", d);
  endtask

  // n bytes in the frame, k actually supplied (k<n forces an underrun);
  // chain leaves s_valid high after the last byte.
  task automatic start_frame(input int d, input int n, input int k, input bit chain);
    bit ok;
    build_frame(d, n, k);
    @(negedge clk);
    if (d == 0) begin
      if (q0.size() > 0) q0.push_back('0);
      foreach (fr[i]) q0.push_back(fr[i]);
    end else begin
      if (q1.size() > 0) q1.push_back('0);
      foreach (fr[i]) q1.push_back(fr[i]);
    end
    for (int j = 0; j < k; j++) begin
      if (j > 0) @(negedge clk);
      drive(d, 1'b1, fb[j], (j == n - 1));
      wait_ready(d, ok);
      if (!ok) begin drive(d, 1'b0, 8'h00, 1'b0); return; end
    end
    if (k < n || !chain) begin
      @(negedge clk);
      drive(d, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && bz0 === 1'b0 && bz1 === 1'b0) begin
        repeat (3) @(negedge clk);
        return;
      end
    end
    miscompares++;
    $display("FAIL idle timeout: got busy=%b/%b expected idle within 3000 cycles", bz0, bz1);
  endtask

  // Per-cycle compare of both instances against their expectation queues.
  always @(posedge clk) begin
    #1;
    cyc++;
    e0 = '0;
    e1 = '0;
    if (q0.size() > 0) e0 = q0.pop_front();
    if (q1.size() > 0) e1 = q1.pop_front();
    chk("d0 enc_din",    din0, e0.din);
    chk("d0 enc_enable", en0,  e0.en);
    chk("d0 bit_stb",    stb0, e0.stb);
    chk("d0 busy",       bz0,  e0.busy);
    chk("d0 s_ready",    rdy0, e0.rdy);
    chk("d0 underrun",   un0,  e0.und);
    chk("d1 enc_din",    din1, e1.din);
    chk("d1 enc_enable", en1,  e1.en);
    chk("d1 bit_stb",    stb1, e1.stb);
    chk("d1 busy",       bz1,  e1.busy);
    chk("d1 s_ready",    rdy1, e1.rdy);
    chk("d1 underrun",   un1,  e1.und);
    if (en0 === 1'b1) en_cnt0++;
    if (rdy0 === 1'b1) begin rdy_cnt0++; rdy_t0.push_back(cyc); end
    if (un0 === 1'b1) und_cnt0++;
    if (bz0 === 1'b0) lowrun0++;
    else begin
      if (lowrun0 > 0) last_lowrun0 = lowrun0;
      lowrun0 = 0;
    end
    if (en1 === 1'b1) en_cnt1++;
    if (stb1 === 1'b1) stb_cnt1++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [43:0] seq;
    int          ri;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // Pin the model against the hand-derived single-byte frame.
    fb[0] = 8'hA5;
    build_frame(0, 1, 1);
    chk("model frame cycles", fr.size(), 88);
    for (int i = 0; i < 44; i++) seq[43-i] = fr[2*i].din;
    chk("model bit sequence", seq, 44'hAAAA2DD4A50);
    ri = -1;
    foreach (fr[i]) if (fr[i].rdy) ri = i;
    chk("model ready cycle", ri, 63);

    // Single byte A5, last.
    en_cnt0 = 0; rdy_cnt0 = 0; und_cnt0 = 0;
    start_frame(0, 1, 1, 1'b0);
    wait_idle();
    chk("A5 enable cycles", en_cnt0, 88);
    chk("A5 ready pulses", rdy_cnt0, 1);

    // Three back-to-back bytes.
    fb[0] = 8'h00; fb[1] = 8'hFF; fb[2] = 8'h3C;
    rdy_t0.delete(); und_cnt0 = 0;
    start_frame(0, 3, 3, 1'b0);
    wait_idle();
    chk("3byte ready pulses", rdy_t0.size(), 3);
    if (rdy_t0.size() >= 3) begin
      chk("3byte ready gap1", rdy_t0[1] - rdy_t0[0], 16);
      chk("3byte ready gap2", rdy_t0[2] - rdy_t0[1], 16);
    end
    chk("3byte underruns", und_cnt0, 0);

    // Underrun on the second byte of a two-byte frame.
    fb[0] = 8'h11; fb[1] = 8'h22;
    rdy_cnt0 = 0; und_cnt0 = 0;
    start_frame(0, 2, 1, 1'b0);
    wait_idle();
    chk("underrun pulses", und_cnt0, 1);
    chk("underrun ready pulses", rdy_cnt0, 1);

    // Back-to-back frames with s_valid held high.
    fb[0] = 8'h5A;
    start_frame(0, 1, 1, 1'b1);
    fb[0] = 8'hC3;
    start_frame(0, 1, 1, 1'b0);
    wait_idle();
    chk("b2b busy low cycles", last_lowrun0, 1);

    // Reset in the middle of a payload byte.
    fb[0] = 8'hE7;
    start_frame(0, 1, 1, 1'b1);
    repeat (9) @(negedge clk);
    rst0 = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    q0.delete();
    @(negedge clk);
    rst0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("post-reset busy", bz0, 1'b0);
    chk("post-reset enc_enable", en0, 1'b0);

    // Short-frame configuration on the second instance.
    fb[0] = 8'h96;
    en_cnt1 = 0; stb_cnt1 = 0;
    start_frame(1, 1, 1, 1'b0);
    wait_idle();
    chk("sweep enable cycles", en_cnt1, 125);
    chk("sweep bit strobes", stb_cnt1, 25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
